// File: rtl/bot_sysreg_bank_if.sv
// ============================================================================
// Module  : bot_sysreg_bank_if
// Brief   : PicoBlaze-style I/O port bus between the CPU and the register bank
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bot_sysreg_bank_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;

  modport master (
    output port_id, out_port, write_strobe, read_strobe,
    input  in_port
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe,
    output in_port
  );
endinterface

`default_nettype wire

// File: rtl/bot_sysreg_bank.sv
// ============================================================================
// Module  : bot_sysreg_bank
// Brief   : Per-robot shadow/visible system registers with atomic commit,
//           sticky update flag and overrun tracking
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bot_sysreg_bank #(
  parameter int         N_BOTS        = 4,
  parameter logic [7:0] RESET_BOTINFO = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  bot_sysreg_bank_if.slave      bus,
  input  logic [8*N_BOTS-1:0]   MotCtl_in,
  output logic [8*N_BOTS-1:0]   LocX_reg,
  output logic [8*N_BOTS-1:0]   LocY_reg,
  output logic [8*N_BOTS-1:0]   Sensors_reg,
  output logic [8*N_BOTS-1:0]   BotInfo_reg,
  output logic [8*N_BOTS-1:0]   LMDist_reg,
  output logic [8*N_BOTS-1:0]   RMDist_reg,
  output logic [N_BOTS-1:0]     upd_sysregs,
  input  logic [N_BOTS-1:0]     upd_ack
);

  localparam logic [3:0] c_NBOTS   = 4'(N_BOTS);
  localparam logic [3:0] c_NREGS   = 4'd6;
  localparam logic [3:0] c_STATUS  = 4'd1;
  localparam logic [3:0] c_COMMIT  = 4'hF;
  localparam int         c_BOTINFO = 3;

  logic [7:0]        r_shadow  [N_BOTS][0:5];
  logic [7:0]        r_visible [N_BOTS][0:5];
  logic [7:0]        r_mot     [N_BOTS];
  logic [N_BOTS-1:0] r_upd;
  logic [N_BOTS-1:0] r_ovr;
  logic [7:0]        r_rdata;

  logic [2:0]        w_bot;
  logic [3:0]        w_reg;
  logic              w_hit;
  logic [N_BOTS-1:0] w_sel;
  logic [N_BOTS-1:0] w_wr;
  logic [N_BOTS-1:0] w_commit;
  logic [N_BOTS-1:0] w_stat_rd;
  logic [7:0]        w_rdata;

  assign w_bot = bus.port_id[6:4];
  assign w_reg = bus.port_id[3:0];
  assign w_hit = !bus.port_id[7] && ({1'b0, w_bot} < c_NBOTS);

  always_comb begin
    w_sel     = '0;
    w_wr      = '0;
    w_commit  = '0;
    w_stat_rd = '0;
    for (int b = 0; b < N_BOTS; b++) begin
      w_sel[b]     = w_hit && (w_bot == 3'(b));
      w_wr[b]      = w_sel[b] && bus.write_strobe;
      w_commit[b]  = w_wr[b] && (w_reg == c_COMMIT);
      w_stat_rd[b] = w_sel[b] && bus.read_strobe && (w_reg == c_STATUS);
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    for (int b = 0; b < N_BOTS; b++) begin
      if (w_sel[b]) begin
        case (w_reg)
          4'd0:    w_rdata = r_mot[b];
          4'd1:    w_rdata = {r_ovr[b], 6'b0, r_upd[b]};
          4'd2:    w_rdata = r_shadow[b][0];
          4'd3:    w_rdata = r_shadow[b][1];
          4'd4:    w_rdata = r_shadow[b][2];
          4'd5:    w_rdata = r_shadow[b][3];
          4'd6:    w_rdata = r_shadow[b][4];
          4'd7:    w_rdata = r_shadow[b][5];
          default: w_rdata = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < N_BOTS; b++) begin
        for (int k = 0; k < 6; k++) begin
          r_shadow[b][k]  <= (k == c_BOTINFO) ? RESET_BOTINFO : 8'h00;
          r_visible[b][k] <= (k == c_BOTINFO) ? RESET_BOTINFO : 8'h00;
        end
        r_mot[b] <= 8'h00;
      end
      r_upd   <= '0;
      r_ovr   <= '0;
      r_rdata <= 8'h00;
    end else begin
      r_rdata <= w_rdata;
      for (int b = 0; b < N_BOTS; b++) begin
        r_mot[b] <= MotCtl_in[8*b +: 8];
        if (w_wr[b] && (w_reg < c_NREGS))
          r_shadow[b][w_reg[2:0]] <= bus.out_port;
        if (w_commit[b])
          r_visible[b] <= r_shadow[b];
        // A commit outranks an ack in the same cycle: the new data still needs acknowledging.
        if (w_commit[b]) begin
          r_upd[b] <= 1'b1;
          if (r_upd[b] && !upd_ack[b])
            r_ovr[b] <= 1'b1;
        end else if (upd_ack[b]) begin
          r_upd[b] <= 1'b0;
          r_ovr[b] <= 1'b0;
        end else if (w_stat_rd[b]) begin
          r_ovr[b] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar gb = 0; gb < N_BOTS; gb++) begin : g_pack
      assign LocX_reg[8*gb +: 8]    = r_visible[gb][0];
      assign LocY_reg[8*gb +: 8]    = r_visible[gb][1];
      assign Sensors_reg[8*gb +: 8] = r_visible[gb][2];
      assign BotInfo_reg[8*gb +: 8] = r_visible[gb][3];
      assign LMDist_reg[8*gb +: 8]  = r_visible[gb][4];
      assign RMDist_reg[8*gb +: 8]  = r_visible[gb][5];
    end
  endgenerate

  assign upd_sysregs = r_upd;
  assign bus.in_port = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_bot_sysreg_bank.sv
// ============================================================================
// Module  : tb_bot_sysreg_bank
// Brief   : Randomized and directed checks of bot_sysreg_bank against a model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bot_sysreg_bank;
  localparam int         NB = 4;
  localparam logic [7:0] RB = 8'hA5;

  logic            clk = 1'b0;
  logic            reset;
  logic [8*NB-1:0] mot;
  logic [8*NB-1:0] locx, locy, sens, binfo, lmd, rmd;
  logic [NB-1:0]   upd, ack;

  bot_sysreg_bank_if bus ();

  bot_sysreg_bank #(.N_BOTS(NB), .RESET_BOTINFO(RB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .MotCtl_in(mot),
    .LocX_reg(locx), .LocY_reg(locy), .Sensors_reg(sens), .BotInfo_reg(binfo),
    .LMDist_reg(lmd), .RMDist_reg(rmd), .upd_sysregs(upd), .upd_ack(ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the CPU has written and what the application can see.
  logic [7:0] m_sh  [NB][6];
  logic [7:0] m_vis [NB][6];
  logic [7:0] m_mot [NB];
  logic [NB-1:0] m_upd, m_ovr;
  logic [7:0] m_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vis_pack(input int k);
    logic [31:0] v;
    for (int b = 0; b < NB; b++) v[8*b +: 8] = m_vis[b][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < 6; k++) begin
        m_sh[b][k]  = (k == 3) ? RB : 8'h00;
        m_vis[b][k] = (k == 3) ? RB : 8'h00;
      end
      m_mot[b] = 8'h00;
    end
    m_upd = '0;
    m_ovr = '0;
    m_in  = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] pid;
    int bi, r;
    bit ok;
    pid = bus.port_id;
    bi  = int'(pid[6:4]);
    r   = int'(pid[3:0]);
    ok  = !pid[7] && bi < NB;
    m_in = 8'h00;
    if (ok) begin
      if (r == 0)               m_in = m_mot[bi];
      else if (r == 1)          m_in = {m_ovr[bi], 6'b0, m_upd[bi]};
      else if (r >= 2 && r <= 7) m_in = m_sh[bi][r-2];
    end
    for (int b = 0; b < NB; b++) m_mot[b] = mot[8*b +: 8];
    for (int b = 0; b < NB; b++) begin
      bit this_bot, commit;
      this_bot = ok && bi == b;
      commit   = this_bot && bus.write_strobe && r == 15;
      if (this_bot && bus.write_strobe && r < 6) m_sh[b][r] = bus.out_port;
      if (commit) begin
        for (int k = 0; k < 6; k++) m_vis[b][k] = m_sh[b][k];
        if (m_upd[b] && !ack[b]) m_ovr[b] = 1'b1;
        m_upd[b] = 1'b1;
      end else if (ack[b]) begin
        m_upd[b] = 1'b0;
        m_ovr[b] = 1'b0;
      end else if (this_bot && bus.read_strobe && r == 1) begin
        m_ovr[b] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("in_port", {24'b0, bus.in_port}, {24'b0, m_in});
    check("upd_sysregs", {28'b0, upd}, {28'b0, m_upd});
    check("LocX", locx, vis_pack(0));
    check("LocY", locy, vis_pack(1));
    check("Sensors", sens, vis_pack(2));
    check("BotInfo", binfo, vis_pack(3));
    check("LMDist", lmd, vis_pack(4));
    check("RMDist", rmd, vis_pack(5));
  endtask

  // Present one bus cycle, clock it, and compare against the model just after the edge.
  task automatic apply(input logic [7:0] pid, input logic [7:0] d,
                       input logic ws, input logic rs, input logic [NB-1:0] a);
    bus.port_id      = pid;
    bus.out_port     = d;
    bus.write_strobe = ws;
    bus.read_strobe  = rs;
    ack              = a;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b0;
    mot = '0;
    ack = '0;
    bus.port_id = 8'h00;
    bus.out_port = 8'h00;
    bus.write_strobe = 1'b0;
    bus.read_strobe = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_port", {24'b0, bus.in_port}, 32'h0);
    check("rst_upd", {28'b0, upd}, 32'h0);
    check("rst_botinfo", binfo, 32'hA5A5A5A5);
    check("rst_locx", locx, 32'h0);
    check("rst_rmdist", rmd, 32'h0);
    reset = 1'b1;

    // Shadow readback after reset
    for (int b = 0; b < NB; b++)
      for (int r = 2; r <= 7; r++) apply({1'b0, 3'(b), 4'(r)}, 8'h00, 1'b0, 1'b0, '0);
    apply(8'h25, 8'h00, 1'b0, 1'b0, '0);
    check("rst_shadow_botinfo", {24'b0, bus.in_port}, 32'hA5);

    // Atomic commit of robot 2
    for (int r = 0; r < 6; r++) apply({4'h2, 4'(r)}, 8'h11 + 8'(r), 1'b1, 1'b0, '0);
    check("pre_commit_locx2", {24'b0, locx[23:16]}, 32'h0);
    apply(8'h2F, 8'h00, 1'b1, 1'b0, '0);
    check("commit_locx", locx, 32'h00110000);
    check("commit_rmdist", rmd, 32'h00160000);
    check("commit_botinfo", binfo, 32'hA514A5A5);
    check("commit_upd", {28'b0, upd}, 32'h4);

    // Double commit on robot 1 -> overrun, then ack clears everything
    apply(8'h1F, 8'h00, 1'b1, 1'b0, '0);
    apply(8'h1F, 8'h00, 1'b1, 1'b0, '0);
    apply(8'h11, 8'h00, 1'b0, 1'b0, '0);
    check("overrun_status", {24'b0, bus.in_port}, 32'h81);
    apply(8'h11, 8'h00, 1'b0, 1'b0, 4'b0010);
    apply(8'h11, 8'h00, 1'b0, 1'b0, '0);
    check("ack_status", {24'b0, bus.in_port}, 32'h00);
    check("ack_upd1", {31'b0, upd[1]}, 32'h0);

    // Commit and ack colliding on a pending robot 0 flag
    apply(8'h0F, 8'h00, 1'b1, 1'b0, '0);
    apply(8'h0F, 8'h00, 1'b1, 1'b0, 4'b0001);
    apply(8'h01, 8'h00, 1'b0, 1'b0, '0);
    check("collide_status", {24'b0, bus.in_port}, 32'h01);

    // Read of status clears overrun but keeps the flag
    apply(8'h0F, 8'h00, 1'b1, 1'b0, '0);
    apply(8'h01, 8'h00, 1'b0, 1'b1, '0);
    check("rdclr_before", {24'b0, bus.in_port}, 32'h81);
    apply(8'h01, 8'h00, 1'b0, 1'b0, '0);
    check("rdclr_after", {24'b0, bus.in_port}, 32'h01);

    // MotCtl path: two cycles from input to in_port
    mot[31:24] = 8'h5C;
    apply(8'h30, 8'h00, 1'b0, 1'b0, '0);
    apply(8'h30, 8'h00, 1'b0, 1'b0, '0);
    check("motctl_read", {24'b0, bus.in_port}, 32'h5C);
    apply(8'h90, 8'h00, 1'b0, 1'b0, '0);
    check("read_bit7", {24'b0, bus.in_port}, 32'h0);
    apply(8'h50, 8'h00, 1'b0, 1'b0, '0);
    check("read_bot5", {24'b0, bus.in_port}, 32'h0);

    // Ignored writes
    apply(8'h47, 8'hFF, 1'b1, 1'b0, '0);
    apply(8'h80, 8'hFF, 1'b1, 1'b0, '0);
    apply(8'hCF, 8'hFF, 1'b1, 1'b0, '0);
    apply(8'h28, 8'hFF, 1'b1, 1'b0, '0);

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      logic [7:0] pid;
      logic [3:0] a;
      int sel;
      if (i % 8 == 0) mot = $urandom;
      pid[7]   = ($urandom_range(0, 15) == 0);
      pid[6:4] = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      pid[3:0] = (sel < 7) ? 4'($urandom_range(0, 7)) :
                 (sel < 9) ? 4'hF : 4'($urandom_range(8, 14));
      for (int b = 0; b < NB; b++) a[b] = ($urandom_range(0, 4) == 0);
      apply(pid, 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), a);
      if (i == 600) begin
        // Asynchronous reset mid-run, applied away from the clock edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_in_port", {24'b0, bus.in_port}, 32'h0);
        check("midrst_upd", {28'b0, upd}, 32'h0);
        check("midrst_botinfo", binfo, 32'hA5A5A5A5);
        check("midrst_locy", locy, 32'h0);
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bot_sysreg_bank.md
# bot_sysreg_bank

Parametrised system-register bank for multi-robot BOTSIM builds. It sits between the BOTSIM PicoBlaze I/O port bus and the application side, and holds one register set per robot: LocX, LocY, Sensors, BotInfo, LMDist and RMDist. The CPU writes each set into shadow storage and then commits it atomically, so the application never sees a half-updated set. On commit, a per-robot sticky update flag is raised and held until the application acknowledges it; a commit that arrives while the flag is still pending is recorded as an overrun.

## Interface
Parameters:
- N_BOTS, 4, number of robot register sets; legal range 1..8.
- RESET_BOTINFO, 8'h00, reset value of every BotInfo register, both shadow and visible.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- port_id  in  8  CPU port address. Bits [6:4] select the robot, bits [3:0] select the register; bit 7 must be 0 for any access to decode.
- out_port  in  8  CPU write data.
- write_strobe  in  1  CPU write qualifier.
- read_strobe  in  1  CPU read qualifier; used only for status side effects.
- in_port  out  8  registered CPU read data.
- MotCtl_in  in  8*N_BOTS  motor control byte per robot; robot i occupies bits [8i+7:8i].
- LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, LMDist_reg, RMDist_reg  out  8*N_BOTS each  committed (visible) registers, packed per robot the same way as MotCtl_in.
- upd_sysregs  out  N_BOTS  sticky per-robot update flag.
- upd_ack  in  N_BOTS  per-robot acknowledge from the application; clears the matching flag.

## Operation
Write decode (port_id[7]==0, write_strobe==1, robot index b < N_BOTS):
- Registers 0..5 write out_port into shadow LocX, LocY, Sensors, BotInfo, LMDist, RMDist of robot b.
- Register 4'hF is commit: all six shadow registers of robot b are copied to the visible registers in the same edge.
- Writes to registers 6..E, to b >= N_BOTS, or with port_id[7]==1 are ignored.

Commit handling for robot b:
- upd_sysregs[b] is set.
- If upd_sysregs[b] was already 1 and upd_ack[b] is not asserted in that cycle, overrun[b] is also set.
- If a commit and upd_ack[b] occur in the same cycle, the flag stays 1 and overrun is not set.

Acknowledge handling:
- upd_ack[b] with no commit to b in that cycle clears upd_sysregs[b] and overrun[b].
- upd_ack bits for b >= N_BOTS do not exist.

Read decode (in_port is loaded every cycle from the current port_id, regardless of read_strobe):
- Register 0: MotCtl sample of robot b. MotCtl_in is registered every cycle into an internal sample stage.
- Register 1: status byte {overrun[b], 6'b0, upd_sysregs[b]}.
- Registers 2..7: read back shadow LocX..RMDist.
- Any other address, or b >= N_BOTS: 8'h00.

Read side effect: read_strobe on register 1 of robot b clears overrun[b] only. upd_sysregs[b] is not affected. If a new overrun for b occurs in the same cycle, setting wins.

Each robot's datapath is independent, so simultaneous activity on different robots never interacts.

## Timing
- Reset (reset==0, asynchronous) forces the following; all values hold until reset is released:
  - all shadow and visible registers to 8'h00, except BotInfo, which takes RESET_BOTINFO;
  - the MotCtl sample stage to 0;
  - upd_sysregs and overrun to 0;
  - in_port to 8'h00.
- Shadow write: write_strobe in cycle N; shadow value readable through in_port from cycle N+2 (port_id in N+1, registered read data in N+2).
- Commit: strobe in cycle N; visible registers and upd_sysregs change at the edge ending N and are valid in N+1. Latency is 1 cycle.
- upd_ack: sampled at the clock edge; the flag drops in the cycle after the ack is seen. Holding ack high for several cycles is legal.
- MotCtl read path: 2 cycles, input change to in_port.
- Reset asserted mid-operation discards pending shadow data. No commit completes during or after reset until a new commit strobe arrives.

## Test plan
- Reset value check: assert reset with RESET_BOTINFO=8'hA5 -> all visible and shadow registers read 0, except BotInfo = 8'hA5; upd_sysregs=0; in_port=0.
- Atomic commit: write robot 2 regs 0..5 = 8'h11..8'h16 -> visible robot-2 registers stay 0. Then write port 8'h2F -> all six visible registers update in the same cycle N+1; upd_sysregs=4'b0100; other robots unchanged.
- Handshake and overrun: commit robot 1 twice with no ack -> status read returns 8'h81. Then pulse upd_ack[1] -> upd_sysregs[1]=0 and status=8'h00.
- Commit/ack collision: commit robot 0 in the same cycle as upd_ack[0] while the flag is pending -> flag stays 1; status reads 8'h01.
- Read mux: MotCtl_in robot 3 = 8'h5C, port_id=8'h30 -> in_port=8'h5C two cycles after the input change. port_id=8'h90 or robot index 5 with N_BOTS=4 -> in_port=8'h00.
- Ignored writes: write_strobe to 8'h47 and to 8'h80 -> no register or flag changes anywhere.
